// File: rtl/shift_out_serializer_if.sv
// Bundle between the start button / pattern source and the serializer.
// slave: serializer side; master: pattern source / observer side.
interface shift_out_serializer_if #(
    parameter int WIDTH = 6
);
    logic             start_n;
    logic [WIDTH-1:0] par_data;
    logic             ser_n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] led;

    modport slave (
        input  start_n,
        input  par_data,
        output ser_n,
        output busy,
        output done,
        output led
    );

    modport master (
        output start_n,
        output par_data,
        input  ser_n,
        input  busy,
        input  done,
        input  led
    );
endinterface

// File: rtl/shift_out_serializer.sv
// Parallel-to-serial LED frame transmitter, MSB first, DIV+1 clks per bit.
// Ports: clk, reset (async, active-low), bus (slave): start_n, par_data in;
// ser_n, busy, done, led out. Optional macro: SERIALIZER_PARITY_EN adds
// one even-parity bit period after the data bits.
module shift_out_serializer #(
    parameter int DIV   = 27000000,
    parameter int WIDTH = 6
) (
    input logic                  clk,
    input logic                  reset,
    shift_out_serializer_if.slave bus
);
    localparam int          BW    = $clog2(WIDTH + 1) + 1;
    localparam logic [31:0] DIV_L = DIV[31:0];
`ifdef SERIALIZER_PARITY_EN
    localparam logic [BW-1:0] LAST = BW'(WIDTH);
`else
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [31:0]      tick, tick_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [BW-1:0]    bitcnt, bitcnt_nx;
    logic             sync1, sync2, hist;
    logic             start_ev;
    logic             ser_n, busy, done;
`ifdef SERIALIZER_PARITY_EN
    logic             par, par_nx;
`endif

    // Button is asynchronous: two sync flops, then edge detect on history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= bus.start_n;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign start_ev = ~sync2 & hist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            tick   <= '0;
            shreg  <= '0;
            bitcnt <= '0;
        end else begin
            state  <= state_nx;
            tick   <= tick_nx;
            shreg  <= shreg_nx;
            bitcnt <= bitcnt_nx;
        end
    end

`ifdef SERIALIZER_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) par <= 1'b0;
        else        par <= par_nx;
    end
`endif

    always_comb begin
        state_nx  = state;
        tick_nx   = tick;
        shreg_nx  = shreg;
        bitcnt_nx = bitcnt;
        ser_n     = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_nx    = par;
`endif
        unique case (state)
            IDLE: begin
                if (start_ev) begin
                    shreg_nx  = bus.par_data;
                    tick_nx   = '0;
                    bitcnt_nx = '0;
                    state_nx  = SHIFT;
`ifdef SERIALIZER_PARITY_EN
                    par_nx    = ^bus.par_data;
`endif
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                ser_n = ~shreg[WIDTH-1];
`ifdef SERIALIZER_PARITY_EN
                // Data has fully shifted out; shreg is zero here.
                if (bitcnt == BW'(WIDTH)) ser_n = ~par;
`endif
                tick_nx = tick + 32'd1;
                if (tick == DIV_L) begin
                    tick_nx   = '0;
                    shreg_nx  = {shreg[WIDTH-2:0], 1'b0};
                    bitcnt_nx = bitcnt + 1'b1;
                    if (bitcnt == LAST) state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.ser_n = ser_n;
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.led   = ~shreg;
endmodule

// File: tb/tb_shift_out_serializer.sv
// Directed bench for shift_out_serializer at DIV=3, WIDTH=6.
// Define SERIALIZER_PARITY_EN here as well as in the RTL for parity builds.
module tb_shift_out_serializer;
    localparam int DIV = 3;
    localparam int W   = 6;
    localparam int BP  = DIV + 1;
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    shift_out_serializer_if #(.WIDTH(W)) bus ();

    shift_out_serializer #(
        .DIV   (DIV),
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // One frame: press at the next negedge, check every cycle of the frame.
    // ser_exp / par_ser are the hand-computed line levels.
    task automatic frame(input logic [W-1:0] pat, input logic [W-1:0] ser_exp,
                         input logic par_ser, input bit hold,
                         input bit glitch, input bit newdata);
        logic [W-1:0] sh;
        logic         es;
        @(negedge clk);
        bus.par_data = pat;
        bus.start_n  = 1'b0;
        @(negedge clk);
        chk("pre0_busy", {31'd0, bus.busy}, 32'd0);
        if (!hold) bus.start_n = 1'b1;
        @(negedge clk);
        chk("pre1_ser", {31'd0, bus.ser_n}, 32'd1);
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < BP; c++) begin
                @(negedge clk);
                es = (i < W) ? ser_exp[W-1-i] : par_ser;
                chk("ser", {31'd0, bus.ser_n}, {31'd0, es});
                chk("busy", {31'd0, bus.busy}, 32'd1);
                chk("done_lo", {31'd0, bus.done}, 32'd0);
                if (c == 0) begin
                    sh = (i < W) ? ~(pat << i) : '1;
                    chk("led", {26'd0, bus.led}, {26'd0, sh});
                end
                if (i == 2 && c == 1) begin
                    if (newdata) bus.par_data = 6'b010101;
                    if (glitch) bus.start_n = 1'b1;
                end
                if (i == 2 && c == 3 && glitch) bus.start_n = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_hi", {23'd0, bus.ser_n, bus.busy, bus.done, bus.led},
            {23'd0, 1'b1, 1'b0, 1'b1, 6'h3f});
        @(negedge clk);
        chk("post", {23'd0, bus.ser_n, bus.busy, bus.done, bus.led},
            {23'd0, 1'b1, 1'b0, 1'b0, 6'h3f});
        bus.start_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.start_n  = 1'b1;
        bus.par_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_hold", {23'd0, bus.ser_n, bus.busy, bus.done, bus.led},
            {23'd0, 1'b1, 1'b0, 1'b0, 6'h3f});
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", {23'd0, bus.ser_n, bus.busy, bus.done, bus.led},
                {23'd0, 1'b1, 1'b0, 1'b0, 6'h3f});
        end

        // basic frame, then held press with mid-frame re-pulse
        frame(6'b101100, 6'b010011, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(6'b101100, 6'b010011, 1'b0, 1'b1, 1'b1, 1'b0);
        // repeated press after done, data change mid-frame
        frame(6'b101100, 6'b010011, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(6'b000000, 6'b111111, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(6'b111111, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(6'b100001, 6'b011110, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset during bit 3
        @(negedge clk);
        bus.par_data = 6'b101100;
        bus.start_n  = 1'b0;
        @(negedge clk);
        bus.start_n = 1'b1;
        repeat (1 + 3 * BP + 2) @(negedge clk);
        chk("mid_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid", {23'd0, bus.ser_n, bus.busy, bus.done, bus.led},
            {23'd0, 1'b1, 1'b0, 1'b0, 6'h3f});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_nodone", {31'd0, bus.done}, 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("after_rst", {23'd0, bus.ser_n, bus.busy, bus.done, bus.led},
                {23'd0, 1'b1, 1'b0, 1'b0, 6'h3f});
        end
        frame(6'b101100, 6'b010011, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/shift_out_serializer.md
Name: shift_out_serializer

Overview:
Parallel-to-serial transmitter that drives the active-low serial data line consumed by the team's LED shift-register receiver.
- On a button press, latches a WIDTH-bit pattern and shifts it out MSB first, one bit per DIV+1 clocks.
- The receiver, running at the same DIV, ends with the pattern on its LEDs.
- Sits on the Tang Nano 9K, 27 MHz clk; mirrors outgoing bits on its own active-low LEDs.

Parameters:
- DIV, 27000000: bit period is DIV+1 clk cycles. The tick counter runs 0..DIV, matching the receiver.
- WIDTH, 6: pattern width in bits. Legal range 2..32.

Ports:
- clk  input  1  system clock, 27 MHz.
- reset  input  1  asynchronous, active-low reset.
- start_n  input  1  active-low start button, asynchronous to clk.
- par_data  input  WIDTH  pattern to send; bit WIDTH-1 is sent first.
- ser_n  output  1  active-low serial data: drives ~bit; idle level 1.
- busy  output  1  high while a frame is being shifted.
- done  output  1  one-cycle pulse after the last bit period.
- led  output  WIDTH  active-low view of the frame shift register.

Behaviour:
- Reset (reset=0, immediate, asynchronous): state=IDLE, ser_n=1, busy=0, done=0, led=all 1s, tick counter=0, bit counter=0. Synchronizer flops are preset to 1.
- start_n synchronization:
  - Passes through a 2-flop synchronizer plus one history flop.
  - Start event = synced value 0 while history value 1, i.e. one falling edge.
  - If start_n is low at rising edge k, the first bit appears on ser_n after edge k+2.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ser_n=1, busy=0.
  - A start event loads shreg<=par_data, clears the tick counter and bit counter, and moves to SHIFT.
  - Without a start event, stays in IDLE.
- SHIFT:
  - busy=1, ser_n=~shreg[WIDTH-1].
  - Tick counter increments every cycle.
  - When the counter equals DIV: counter<=0, shreg<={shreg[WIDTH-2:0],1'b0}, bit counter increments.
  - When the counter equals DIV on the last frame bit: move to DONE.
  - Each bit is held exactly DIV+1 cycles.
- DONE: lasts one cycle; done=1, busy=0, ser_n=1; then IDLE.
- led = ~shreg at all times. Bits turn off as they leave; all 1s in IDLE after reset.
- par_data is latched only at the start event. Changes during SHIFT have no effect.
- Start events during SHIFT or DONE are ignored, not queued.
- A held-low start_n produces one frame only. A new frame needs a release then a press.
- Start event in the same cycle DONE is entered: ignored.
- Reset mid-frame: aborts immediately to reset values; done is not pulsed.
- Tick counter width is 32 bits. Bit counter width is clog2(WIDTH+1)+1; no wrap occurs inside a frame.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- When defined: after the WIDTH data bits, one extra bit period of DIV+1 cycles carries even parity P = XOR of the latched data.
  - ser_n = ~P during that period.
  - The frame is WIDTH+1 bit periods; busy covers all of them.
  - led shows all 1s during the parity bit.
- When undefined: the frame is exactly WIDTH bit periods and no parity logic is synthesized.

Test Plan:
- Reset check: DIV=3, hold reset=0 -> ser_n=1, busy=0, done=0, led=6'b111111. Release reset with start_n=1 -> outputs unchanged for 20 cycles.
- Basic frame:
  - Stimulus: DIV=3, par_data=6'b101100, drive start_n low at edge k.
  - ser_n from edge k+2 = 0,1,0,0,1,1, each bit held 4 cycles.
  - busy high 24 cycles, then done=1 for exactly 1 cycle, then ser_n=1.
  - led steps 010011, 100111, 001111, 011111, 111111, 111111.
- Held and repeated start:
  - Hold start_n low across the whole frame and pulse it again mid-frame -> exactly one 24-cycle frame.
  - Release and press after done -> second identical frame begins 2 cycles after the press.
- Data latching: change par_data to 6'b010101 during bit 2 -> the transmitted sequence stays 0,1,0,0,1,1.
- Reset mid-frame:
  - Assert reset during bit 3 -> same cycle ser_n=1, busy=0, led=111111; no done pulse.
  - After release, a press sends the full frame from bit 5.
- Parity (SERIALIZER_PARITY_EN defined):
  - par_data=6'b101100 -> 7th bit ser_n=0, busy 28 cycles.
  - par_data=6'b000000 -> 7th bit ser_n=1 (even parity 0 sent as line high).
